// File: rtl/decoder_1to2_2to4.sv
// rtl/decoder_1to2_2to4.sv - registered 1-to-2, 2-to-4 and cascaded 3-to-8 one-hot decoders
module decoder_1to2_2to4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in1,
  input  logic       e1,
  input  logic [1:0] in2,
  input  logic       e2,
  input  logic [2:0] in3,
  input  logic       e3,
  output logic [1:0] out2,
  output logic [3:0] out4,
  output logic [7:0] out8
);

  function automatic logic [1:0] dec1to2(input logic en, input logic sel);
    dec1to2 = {en & sel, en & ~sel};
  endfunction

  function automatic logic [3:0] dec2to4(input logic en, input logic [1:0] sel);
    dec2to4 = {en & (sel == 2'd3),
               en & (sel == 2'd2),
               en & (sel == 2'd1),
               en & (sel == 2'd0)};
  endfunction

  logic [1:0] out2_d;
  logic [3:0] out4_d;
  logic [1:0] x;
  logic [3:0] hi_d;
  logic [3:0] lo_d;
  logic [7:0] out8_d;

  // 3-to-8: stage A splits on in3[2]; its one-hot outputs enable the upper/lower 2-to-4 stages
  always_comb begin
    out2_d = dec1to2(e1, in1);
    out4_d = dec2to4(e2, in2);
    x      = dec1to2(e3, in3[2]);
    hi_d   = dec2to4(x[1], in3[1:0]);
    lo_d   = dec2to4(x[0], in3[1:0]);
    out8_d = {hi_d, lo_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out2 <= 2'b00;
      out4 <= 4'h0;
      out8 <= 8'h00;
    end else begin
      out2 <= out2_d;
      out4 <= out4_d;
      out8 <= out8_d;
    end
  end

endmodule

// File: tb/tb_decoder_1to2_2to4.sv
// tb/tb_decoder_1to2_2to4.sv - scoreboard bench for decoder_1to2_2to4
module tb_decoder_1to2_2to4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in1 = 1'b0;
  logic       e1 = 1'b0;
  logic [1:0] in2 = 2'd0;
  logic       e2 = 1'b0;
  logic [2:0] in3 = 3'd0;
  logic       e3 = 1'b0;
  logic [1:0] out2;
  logic [3:0] out4;
  logic [7:0] out8;

  int checks = 0;
  int fails  = 0;

  logic [13:0] exp_q[$];
  string       name_q[$];

  localparam logic [7:0] SWEEP8 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  localparam logic [3:0] SWEEP4 [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

  decoder_1to2_2to4 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .e1   (e1),
    .in2  (in2),
    .e2   (e2),
    .in3  (in3),
    .e3   (e3),
    .out2 (out2),
    .out4 (out4),
    .out8 (out8)
  );

  always #5 clk = ~clk;

  task automatic compare(input string nm, input logic [13:0] act, input logic [13:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got out2=%b out4=%h out8=%h, required out2=%b out4=%h out8=%h",
               nm, act[13:12], act[11:8], act[7:0], expv[13:12], expv[11:8], expv[7:0]);
    end
  endtask

  // Drive one vector at the falling edge; its result is due after the next rising edge
  task automatic vec(input logic r, input logic e1v, input logic in1v,
                     input logic e2v, input logic [1:0] in2v,
                     input logic e3v, input logic [2:0] in3v,
                     input logic [1:0] x2, input logic [3:0] x4, input logic [7:0] x8,
                     input string nm);
    @(negedge clk);
    rst_n = r;
    e1 = e1v; in1 = in1v;
    e2 = e2v; in2 = in2v;
    e3 = e3v; in3 = in3v;
    exp_q.push_back({x2, x4, x8});
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    logic [13:0] expv;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        nm   = name_q.pop_front();
        compare(nm, {out2, out4, out8}, expv);
      end
    end
  end

  initial begin : stim
    int wait_cycles;
    #1;
    compare("reset_async_at_start", {out2, out4, out8}, 14'h0);

    for (int i = 0; i < 3; i++)
      vec(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 3'd7, 2'b00, 4'h0, 8'h00, $sformatf("reset_hold_%0d", i));
    vec(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 3'd7, 2'b10, 4'h8, 8'h80, "reset_release_first");

    for (int i = 0; i < 8; i++)
      vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'(i), 2'b00, 4'h0, SWEEP8[i], $sformatf("sweep8_%0d", i));
    vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 2'b00, 4'h0, 8'h01, "sweep8_wrap");

    for (int i = 0; i < 4; i++)
      vec(1'b1, 1'b0, 1'b0, 1'b1, 2'(i), 1'b0, 3'd0, 2'b00, SWEEP4[i], 8'h00, $sformatf("sweep4_%0d", i));
    vec(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 2'b01, 4'h0, 8'h00, "sweep2_0");
    vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 2'b10, 4'h0, 8'h00, "sweep2_1");

    vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd5, 2'b00, 4'h0, 8'h00, "gate_e3_off");
    vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd5, 2'b00, 4'h0, 8'h20, "gate_e3_on");
    vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 3'd5, 2'b00, 4'h0, 8'h00, "gate_e2_off");
    vec(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 3'd5, 2'b00, 4'h4, 8'h00, "gate_e2_on");
    vec(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3'd5, 2'b00, 4'h0, 8'h00, "gate_e1_off");
    vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 3'd5, 2'b10, 4'h0, 8'h00, "gate_e1_on");

    vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 3'd4, 2'b10, 4'h0, 8'h10, "independence");

    for (int i = 0; i < 4; i++)
      vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'(i), 2'b00, 4'h0, SWEEP8[i], $sformatf("mid_sweep_%0d", i));
    vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd4, 2'b00, 4'h0, 8'h10, "mid_after_reset_4");
    #2 rst_n = 1'b0;
    #1 compare("mid_reset_async_clear", {out2, out4, out8}, 14'h0);
    #1 rst_n = 1'b1;
    for (int i = 5; i < 8; i++)
      vec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'(i), 2'b00, 4'h0, SWEEP8[i], $sformatf("mid_resume_%0d", i));

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
